result_stream_packer: RTL

RESULT_STREAM_PACKER -- requirements
Module: result_stream_packer

---
 rtl/result_stream_pkg.sv | 18 +
 rtl/frame_fifo.sv | 61 ++++++
 rtl/result_stream_packer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/result_stream_pkg.sv
// Shared types and constants for the result stream packer.
// RESULT_STREAM_HEADER_EN, when defined, enables a header word at the start of each frame.
package result_stream_pkg;

  localparam logic [7:0]  HDR_MAGIC = 8'hA5;
  localparam int unsigned ST_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } rsp_state_e;

  function automatic int unsigned words_per_frame(input int unsigned nch, input int unsigned dw);
    return (nch * dw) / ST_W;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Single-clock frame FIFO. The head entry is always presented on o_rd_data one cycle
// after it lands. The head slot is released only by i_rd.
module frame_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic [AW:0]      w_rd_ptr_nxt;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_bypass;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign o_count      = w_count;
  assign o_full       = (w_count == (AW+1)'(DEPTH));
  assign o_empty      = (r_wr_ptr == r_rd_ptr);
  assign o_rd_data    = r_rd_data;
  assign w_rd_acc     = i_rd & ~o_empty;
  // A pop from a full FIFO frees the slot the same-cycle write lands in.
  assign w_wr_acc     = i_wr & (~o_full | w_rd_acc);
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_rd_acc};
  assign w_bypass     = w_wr_acc && (r_wr_ptr[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_rd_data <= w_bypass ? i_wr_data : r_mem[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/result_stream_packer.sv
// Captures multi-channel result frames and streams them as 32-bit Avalon-ST words.
// Define RESULT_STREAM_HEADER_EN to prefix every frame with a header word.
//
// state   | meaning
// IDLE    | no frame in flight, waiting for the FIFO head
// HDR     | presenting the header word (header build only)
// DATA    | presenting data word r_widx of the head frame
module result_stream_packer
  import result_stream_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                reset_op,
  input  logic                result_valid,
  input  logic [NCH*DW-1:0]   result_data,
  input  logic [31:0]         n_frames,
  output logic                st_valid,
  input  logic                st_ready,
  output logic [31:0]         st_data,
  output logic                st_sop,
  output logic                st_eop,
  output logic                overflow,
  output logic [31:0]         frames_sent,
  output logic                finalizacion
);

  localparam int FW  = NCH * DW;
  localparam int SW  = int'(ST_W);
  localparam int W   = int'(words_per_frame(NCH, DW));
  localparam int WIX = (W > 1) ? $clog2(W) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
`ifdef RESULT_STREAM_HEADER_EN
  localparam rsp_state_e S_FIRST = ST_HDR;
`else
  localparam rsp_state_e S_FIRST = ST_DATA;
`endif

  rsp_state_e       r_state, w_state_nxt;
  logic [WIX-1:0]   r_widx, w_widx_nxt;
  logic             r_overflow;
  logic [31:0]      r_frames_sent;
  logic             r_fin;

  logic [FW-1:0]    w_frame;
  logic [SW-1:0]    w_words [W];
  logic             w_full, w_empty;
  logic [CW-1:0]    w_count;
  logic             w_push_req, w_xfer, w_eop_acc, w_last;
  logic             w_limit_hit, w_last_frame, w_start, w_more;

  frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (reset_op),
    .i_wr      (w_push_req),
    .i_wr_data (result_data),
    .i_rd      (w_eop_acc),
    .o_rd_data (w_frame),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_comb begin
    for (int i = 0; i < W; i++) w_words[i] = w_frame[i*SW +: SW];
  end

  assign w_push_req   = result_valid & enable & ~r_fin;
  assign w_xfer       = st_valid & st_ready;
  assign w_eop_acc    = w_xfer & st_eop;
  assign w_last       = (r_widx == WIX'(W-1));
  assign w_limit_hit  = (n_frames != 32'd0) && (r_frames_sent == n_frames);
  assign w_last_frame = (n_frames != 32'd0) && (r_frames_sent + 32'd1 == n_frames);
  assign w_start      = ~w_empty & ~w_limit_hit & ~r_fin;
  // Chain straight into the next frame only if one remains once the head is released.
  assign w_more       = (w_count > CW'(1)) & ~w_last_frame & ~w_limit_hit & ~r_fin;

  always_comb begin
    w_state_nxt = r_state;
    w_widx_nxt  = r_widx;
    case (r_state)
      ST_IDLE: if (w_start) begin
        w_state_nxt = S_FIRST;
        w_widx_nxt  = '0;
      end
`ifdef RESULT_STREAM_HEADER_EN
      ST_HDR:  if (w_xfer) w_state_nxt = ST_DATA;
`endif
      ST_DATA: if (w_xfer) begin
        if (w_last) begin
          w_widx_nxt  = '0;
          w_state_nxt = w_more ? S_FIRST : ST_IDLE;
        end else begin
          w_widx_nxt  = r_widx + WIX'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_widx        <= '0;
      r_overflow    <= 1'b0;
      r_frames_sent <= '0;
      r_fin         <= 1'b0;
    end else if (reset_op) begin
      r_state       <= ST_IDLE;
      r_widx        <= '0;
      r_overflow    <= 1'b0;
      r_frames_sent <= '0;
      r_fin         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_widx        <= w_widx_nxt;
      r_overflow    <= r_overflow | (w_push_req & w_full & ~w_eop_acc);
      r_frames_sent <= r_frames_sent + {31'd0, w_eop_acc};
      r_fin         <= r_fin | w_limit_hit;
    end
  end

  always_comb begin
    st_valid = (r_state != ST_IDLE);
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_data  = '0;
    case (r_state)
`ifdef RESULT_STREAM_HEADER_EN
      ST_HDR: begin
        st_sop  = 1'b1;
        st_data = {HDR_MAGIC, 8'(NCH), r_frames_sent[15:0]};
      end
`endif
      ST_DATA: begin
`ifndef RESULT_STREAM_HEADER_EN
        st_sop  = (r_widx == '0);
`endif
        st_eop  = w_last;
        st_data = w_words[r_widx];
      end
      default: ;
    endcase
  end

  assign overflow     = r_overflow;
  assign frames_sent  = r_frames_sent;
  assign finalizacion = r_fin;

endmodule
